// File: rtl/mips_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_mux_pkg
//  Description : Shared datapath-select definitions for the 2:1 / 4:1 muxes
//                and the registered 1-to-4 demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mux_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned SEL_W  = 2;

    // Destination select encodings (sl value -> lane)
    typedef enum logic [SEL_W-1:0] {
        SEL_L1 = 2'd0,
        SEL_L2 = 2'd1,
        SEL_L3 = 2'd2,
        SEL_L4 = 2'd3
    } sel_e;

endpackage : mips_mux_pkg
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
// ============================================================================
//  Module      : demux_lane
//  Description : One-entry holding buffer with valid/ready drain. A write on
//                the same edge as a drain keeps the lane full with the new
//                word, so an always-ready sink sees one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             full;
    logic [WIDTH-1:0] buffer;

    // Full flag: flush beats write, write beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (full && ready) begin
            full <= 1'b0;
        end
    end

    // Buffer contents: loaded on write, otherwise held (not cleared on drain)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
        end else if (wr_en && !flush) begin
            buffer <= wr_data;
        end
    end

    assign valid = full;
    assign data  = buffer;

endmodule : demux_lane
`default_nettype wire

// File: rtl/demux1x4_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x4_reg
//  Description : Registered 1-to-4 demultiplexer. Steers one source word to
//                the lane chosen by sl; each lane has its own one-entry
//                buffer so a stalled sink only blocks traffic aimed at it.
//                Optional per-lane accepted-word counters: DEMUX_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x4_reg
    import mips_mux_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       sl,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    output logic             out4_valid,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    input  logic             out4_ready
`ifdef DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [CNT_W-1:0] cnt4
`endif
);

    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] wr_en;
    logic [WIDTH-1:0] lane_data [LANES];
    logic             accept;

    assign lane_ready = {out4_ready, out3_ready, out2_ready, out1_ready};

    // Selected lane can take a word if empty or draining this cycle;
    // held low during reset and flush
    always_comb begin
        in_ready = rst_n && !flush && (!lane_valid[sl] || lane_ready[sl]);
    end

    assign accept = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign wr_en[i] = accept && (sl == SEL_W'(i));

        demux_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .wr_en   (wr_en[i]),
            .wr_data (in_data),
            .ready   (lane_ready[i]),
            .valid   (lane_valid[i]),
            .data    (lane_data[i])
        );
    end

    assign out1_valid = lane_valid[SEL_L1];
    assign out2_valid = lane_valid[SEL_L2];
    assign out3_valid = lane_valid[SEL_L3];
    assign out4_valid = lane_valid[SEL_L4];
    assign out1       = lane_data[SEL_L1];
    assign out2       = lane_data[SEL_L2];
    assign out3       = lane_data[SEL_L3];
    assign out4       = lane_data[SEL_L4];

`ifdef DEMUX_STATS_EN
    for (genvar i = 0; i < LANES; i++) begin : g_cnt
        logic [CNT_W-1:0] count;

        // Accepted-word counter; wraps naturally, survives flush
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
            end else if (wr_en[i]) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign cnt1 = g_cnt[0].count;
    assign cnt2 = g_cnt[1].count;
    assign cnt3 = g_cnt[2].count;
    assign cnt4 = g_cnt[3].count;
`endif

endmodule : demux1x4_reg
`default_nettype wire

// File: tb/tb_demux1x4_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x4_reg
//  Description : Directed self-checking bench for demux1x4_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x4_reg;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [1:0]       sl;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out1_valid, out2_valid, out3_valid, out4_valid;
    logic [WIDTH-1:0] out1, out2, out3, out4;
    logic             out1_ready, out2_ready, out3_ready, out4_ready;
`ifdef DEMUX_STATS_EN
    logic [15:0]      cnt1, cnt2, cnt3, cnt4;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    demux1x4_reg #(
        .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
       ,.CNT_W (16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .sl         (sl),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .out4_valid (out4_valid),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out1_ready (out1_ready),
        .out2_ready (out2_ready),
        .out3_ready (out3_ready),
        .out4_ready (out4_ready)
`ifdef DEMUX_STATS_EN
       ,.cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .cnt4       (cnt4)
`endif
    );

    // Advance one active edge, then return to the quiet falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; sl = 2'd2; in_valid = 1'b1;
        in_data = 32'hCAFE_F00D;
        out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0; out4_ready = 1'b0;
        step(); step();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        tests_run++;
        if ({out1_valid, out2_valid, out3_valid, out4_valid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_valids got %b want 0000", {out1_valid, out2_valid, out3_valid, out4_valid});
        end
        tests_run++;
        if ((out1 | out2 | out3 | out4) !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h %h %h %h want 0", out1, out2, out3, out4);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
        step();
        tests_run++;
        if (out3_valid !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_no_write got %b want 0", out3_valid);
        end
    endtask

    task automatic test_basic_steer();
        sl = 2'd1; in_data = 32'hDEAD_BEEF; in_valid = 1'b1; out2_ready = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL steer_in_ready got %b want 1", in_ready);
        end
        step();
        in_data = 32'h1111_1111;
        #1;
        tests_run++;
        if (out2_valid !== 1'b1 || out2 !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL steer_out2 got v=%b d=%h want v=1 d=deadbeef", out2_valid, out2);
        end
        tests_run++;
        if ({out1_valid, out3_valid, out4_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL steer_others got %b want 000", {out1_valid, out3_valid, out4_valid});
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL steer_full_stall got %b want 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out2 !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL steer_no_overwrite got %h want deadbeef", out2);
        end
    endtask

    task automatic test_backpressure();
        sl = 2'd3; in_data = 32'h1234_5678; in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_in_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out4_valid !== 1'b1 || out4 !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL bp_out4 got v=%b d=%h want v=1 d=12345678", out4_valid, out4);
        end
        tests_run++;
        if (out2_valid !== 1'b1 || out2 !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL bp_lane2_hold got v=%b d=%h want v=1 d=deadbeef", out2_valid, out2);
        end
        out4_ready = 1'b1;
        step();
        out4_ready = 1'b0;
        tests_run++;
        if (out4_valid !== 1'b0 || out4 !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL drain_hold got v=%b d=%h want v=0 d=12345678", out4_valid, out4);
        end
    endtask

    task automatic test_streaming();
        sl = 2'd0; out1_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = k; in_valid = 1'b1;
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL stream_in_ready[%0d] got %b want 1", k, in_ready);
            end
            step();
            tests_run++;
            if (out1_valid !== 1'b1 || out1 !== WIDTH'(k)) begin
                tests_failed++;
                $display("FAIL stream_out1[%0d] got v=%b d=%h want v=1 d=%h", k, out1_valid, out1, WIDTH'(k));
            end
        end
        in_valid = 1'b0;
        step();
        out1_ready = 1'b0;
        tests_run++;
        if (out1_valid !== 1'b0 || out1 !== 32'd8) begin
            tests_failed++; $display("FAIL stream_end got v=%b d=%h want v=0 d=8", out1_valid, out1);
        end
    endtask

    task automatic test_drain_refill();
        // lane2 holds DEADBEEF; drain and refill on the same edge
        sl = 2'd1; in_data = 32'hB1B1_B1B1; in_valid = 1'b1; out2_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL refill_in_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0; out2_ready = 1'b0;
        tests_run++;
        if (out2_valid !== 1'b1 || out2 !== 32'hB1B1_B1B1) begin
            tests_failed++; $display("FAIL refill_out2 got v=%b d=%h want v=1 d=b1b1b1b1", out2_valid, out2);
        end
    endtask

    task automatic test_flush();
        sl = 2'd0; in_data = 32'hA1; in_valid = 1'b1;
        step();
        sl = 2'd2; in_data = 32'hA3;
        step();
        tests_run++;
        if ({out1_valid, out2_valid, out3_valid} !== 3'b111) begin
            tests_failed++;
            $display("FAIL flush_setup got %b want 111", {out1_valid, out2_valid, out3_valid});
        end
        sl = 2'd0; in_data = 32'hFF; flush = 1'b1; out1_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; out1_ready = 1'b0;
        tests_run++;
        if ({out1_valid, out2_valid, out3_valid, out4_valid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flush_valids got %b want 0000", {out1_valid, out2_valid, out3_valid, out4_valid});
        end
        tests_run++;
        if (out1 !== 32'hA1 || out3 !== 32'hA3) begin
            tests_failed++; $display("FAIL flush_no_accept got %h %h want a1 a3", out1, out3);
        end
    endtask

    task automatic test_reset_midflight();
        sl = 2'd1; in_data = 32'h5555_AAAA; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out2_valid !== 1'b0 || out2 !== 32'h0) begin
            tests_failed++; $display("FAIL async_reset got v=%b d=%h want v=0 d=0", out2_valid, out2);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        tests_run++;
        if ({cnt1, cnt2, cnt3, cnt4} !== 64'h0) begin
            tests_failed++; $display("FAIL cnt_reset got %h %h %h %h want 0", cnt1, cnt2, cnt3, cnt4);
        end
        sl = 2'd2; out3_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            in_data = k;
            step();
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (cnt3 !== 16'd1 || {cnt1, cnt2, cnt4} !== 48'h0) begin
            tests_failed++; $display("FAIL cnt_wrap got %h %h %h %h want 0 0 1 0", cnt1, cnt2, cnt3, cnt4);
        end
        flush = 1'b1;
        step();
        flush = 1'b0; out3_ready = 1'b0;
        tests_run++;
        if (cnt3 !== 16'd1) begin
            tests_failed++; $display("FAIL cnt_flush got %h want 1", cnt3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_steer();
        test_backpressure();
        test_streaming();
        test_drain_refill();
        test_flush();
        test_reset_midflight();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_demux1x4_reg
`default_nettype wire

// File: doc/demux1x4_reg.md
Name: demux1x4_reg

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the datapath 4:1 select; steers one 32-bit source word to one of four destination lanes chosen by a 2-bit select.
- Each lane owns a one-entry holding register with a valid/ready handshake, so a stalled destination back-pressures only traffic aimed at it.
- Sits between the write-back/store source and multiple sinks (register file port, data memory, MMIO, debug tap).

Parameters:
- WIDTH, 32, data width of input and every output lane
- CNT_W, 16, width of per-lane transfer counters (used only with DEMUX_STATS_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all lane buffers
- sl  input  2  destination select: 0→lane1, 1→lane2, 2→lane3, 3→lane4
- in_valid  input  1  source word valid
- in_data  input  WIDTH  source word
- in_ready  output  1  word accepted this cycle when in_valid & in_ready
- out1_valid … out4_valid  output  1 each  lane buffer holds a word
- out1 … out4  output  WIDTH each  lane buffer contents
- out1_ready … out4_ready  input  1 each  lane sink consumes the word this cycle
- cnt1 … cnt4  output  CNT_W each  per-lane accepted-word counts (present only with DEMUX_STATS_EN)

Behaviour:
- Reset (rst_n low, asynchronous): all lane full flags 0, all outN_valid 0, all outN 0, all counters 0; in_ready reads 0 while rst_n is low.
- Lane state per lane i: EMPTY (full=0) / FULL (full=1). outi_valid = full_i; outi = buffer_i.
- in_ready = !flush & (!full[sl] | outsl_ready). Combinational on sl, flush, full, and ready of the selected lane only.
- Accept: in_valid & in_ready at a clock edge writes in_data into buffer[sl]; full[sl]=1 next cycle. Latency is exactly one cycle from accept to outN_valid.
- Drain: outi_valid & outi_ready clears full_i at the edge, unless the same edge accepts a new word into lane i, in which case full_i stays 1 and the buffer takes the new word. This gives full throughput of one word per cycle into a lane whose sink is always ready.
- Lanes not selected are unaffected by the input; their buffers hold steady while FULL and not ready. outN holds its last value when EMPTY; it is not cleared.
- in_data and sl are don't-care when in_valid=0. No write occurs and in_ready stays computed.
- flush=1: all full flags clear at the edge, no input accepted, counters unchanged. flush has priority over simultaneous accept and drain.
- Ordering is preserved per lane only. No ordering guarantee exists across lanes.
- Reset asserted mid-transfer discards buffered words; no partial state survives.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: ports cnt1..cnt4 exist. cnti increments by 1 on each accepted word to lane i and wraps modulo 2^CNT_W (0xFFFF+1 → 0). Counters are reset only by rst_n, not by flush.
- Not defined: no counter ports or registers. Handshake behaviour is identical.

Decomposition:
- Shared package mips_mux_pkg: DATA_W=32, LANES=4, select encodings SEL_L1..SEL_L4 (0..3), reused by the existing 2:1/4:1 muxes and this block.
- One natural sub-module: demux_lane, a one-entry buffer with wr_en, wr_data, flush, valid, ready and data out. It is instanced four times. The top level holds select decode, in_ready mux, and the optional counters.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, sl=2 → in_ready=0, all outN_valid=0, outN=0; release rst_n, next cycle in_ready=1.
- Basic steer: sl=1, in_data=0xDEADBEEF, out2_ready=0 → cycle+1 out2_valid=1, out2=0xDEADBEEF; other lanes stay invalid; next word with sl=1 sees in_ready=0.
- Back-pressure isolation: lane2 FULL and stalled; send sl=3, data=0x12345678 → accepted (in_ready=1), out4=0x12345678 next cycle; lane2 unchanged.
- Streaming: sl=0, out1_ready=1, words 1..8 on consecutive cycles → in_ready constant 1, out1 shows 1..8 one cycle delayed, no bubbles.
- Flush priority: lanes 1 and 3 FULL, flush=1 with in_valid=1, sl=0 → in_ready=0, next cycle all outN_valid=0, no word accepted.
- Stats (DEMUX_STATS_EN, CNT_W=16): preload cnt3 near wrap by sending 65537 words to sl=2 → cnt3=1, other counts 0; flush leaves counts unchanged.
